// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if -- bundle of requester-side and SPI-controller-side signals
// for the two-requester SPI arbiter.
//
//   i_req[1:0]                 per-requester burst request
//   o_gnt[1:0]                 one-hot grant, held for the whole burst
//   i_tx_data0/1, i_tx_last0/1 next TX word and end-of-burst flag per requester
//   o_tx_ready                 word/last of the granted requester captured this cycle
//   o_rx_data, o_rx_valid      received word for the granted requester
//   o_timeout                  burst aborted: no done within the allowed window
//   o_spi_start, o_spi_data    start pulse and TX word to the SPI controller
//   i_spi_data, i_spi_done     RX word and word-complete pulse from the controller
//   i_spi_busy                 controller busy flag
//
// slave  : the arbiter's view.
// master : the requesters plus the SPI controller.
interface spi_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [1:0]            i_req;
  logic [1:0]            o_gnt;
  logic [DATA_WIDTH-1:0] i_tx_data0;
  logic [DATA_WIDTH-1:0] i_tx_data1;
  logic                  i_tx_last0;
  logic                  i_tx_last1;
  logic                  o_tx_ready;
  logic [DATA_WIDTH-1:0] o_rx_data;
  logic                  o_rx_valid;
  logic                  o_timeout;
  logic                  o_spi_start;
  logic [DATA_WIDTH-1:0] o_spi_data;
  logic [DATA_WIDTH-1:0] i_spi_data;
  logic                  i_spi_done;
  logic                  i_spi_busy;

  modport slave (
    input  i_req, i_tx_data0, i_tx_data1, i_tx_last0, i_tx_last1,
           i_spi_data, i_spi_done, i_spi_busy,
    output o_gnt, o_tx_ready, o_rx_data, o_rx_valid, o_timeout,
           o_spi_start, o_spi_data
  );

  modport master (
    output i_req, i_tx_data0, i_tx_data1, i_tx_last0, i_tx_last1,
           i_spi_data, i_spi_done, i_spi_busy,
    input  o_gnt, o_tx_ready, o_rx_data, o_rx_valid, o_timeout,
           o_spi_start, o_spi_data
  );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter -- round-robin arbiter that lets two requesters share one SPI
// controller, one burst at a time. A burst is a sequence of words ending on
// the word whose last flag is set, or aborted when the controller does not
// answer a word within TIMEOUT cycles.
//
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous active-high reset
//   bus    spi_arbiter_if.slave (requester handshake + SPI controller side)
//
// Parameters:
//   DATA_WIDTH  SPI word width (must match the interface instance)
//   TIMEOUT     cycles allowed per word between start pulse and done pulse
module spi_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic         i_clk,
  input  logic         i_rst,
  spi_arbiter_if.slave bus
);

  localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RELEASE} state_t;

  state_t                state;
  logic                  ptr;      // requester served by the previous burst
  logic                  sel;      // requester owning the current burst
  logic                  tx_last;
  logic [DATA_WIDTH-1:0] tx_word;
  logic [CW-1:0]         cnt;
  logic                  pick;

  // A lone request wins outright; on contention the one not served last wins.
  always_comb begin
    pick = bus.i_req[1];
    if (bus.i_req == 2'b11) pick = ~ptr;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: every register, outputs included, has a defined reset value so a
      // burst interrupted by reset leaves nothing behind.
      state           <= IDLE;
      ptr             <= 1'b1;   // "last served = 1" makes requester 0 favoured
      sel             <= 1'b0;
      tx_last         <= 1'b0;
      tx_word         <= '0;
      cnt             <= '0;
      bus.o_gnt       <= 2'b00;
      bus.o_tx_ready  <= 1'b0;
      bus.o_rx_valid  <= 1'b0;
      bus.o_timeout   <= 1'b0;
      bus.o_spi_start <= 1'b0;
      bus.o_spi_data  <= '0;
      bus.o_rx_data   <= '0;
    end else begin
      // NOTE: pulse outputs default low here; a later non-blocking assignment
      // in the case below overrides this for the one cycle it should be high.
      bus.o_tx_ready  <= 1'b0;
      bus.o_rx_valid  <= 1'b0;
      bus.o_timeout   <= 1'b0;
      bus.o_spi_start <= 1'b0;

      case (state)
        IDLE: begin
          if (|bus.i_req) begin
            sel            <= pick;
            bus.o_gnt      <= pick ? 2'b10 : 2'b01;
            // Raised on entry so the pulse coincides with the LOAD cycle,
            // i.e. the cycle whose data is captured.
            bus.o_tx_ready <= 1'b1;
            state          <= LOAD;
          end
        end

        LOAD: begin
          tx_word <= sel ? bus.i_tx_data1 : bus.i_tx_data0;
          tx_last <= sel ? bus.i_tx_last1 : bus.i_tx_last0;
          state   <= START;
        end

        START: begin
          if (!bus.i_spi_busy) begin
            bus.o_spi_start <= 1'b1;
            bus.o_spi_data  <= tx_word;
            cnt             <= '0;
            state           <= WAIT;
          end
        end

        WAIT: begin
          // done is tested first so it wins over a coincident timeout.
          if (bus.i_spi_done) begin
            bus.o_rx_data  <= bus.i_spi_data;
            bus.o_rx_valid <= 1'b1;
            if (tx_last) begin
              state <= RELEASE;
            end else begin
              bus.o_tx_ready <= 1'b1;
              state          <= LOAD;
            end
          end else if (cnt == CNT_LAST) begin
            bus.o_timeout <= 1'b1;
            state         <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RELEASE: begin
          bus.o_gnt <= 2'b00;
          ptr       <= sel;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter -- scoreboard bench for spi_arbiter. Requester queues feed
// i_req/i_tx_*; an SPI controller model answers each start with the inverted
// word after a programmable delay. Expected grants, start words, RX words and
// timeouts are queued when stimulus is issued and popped as the DUT emits them.
module tb_spi_arbiter;

  localparam int DW = 8;
  localparam int TO = 32;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  spi_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  spi_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  word_t         q0[$];
  word_t         q1[$];
  logic [DW-1:0] exp_start[$];
  logic [DW-1:0] exp_rx[$];
  logic [1:0]    exp_gnt[$];
  int            exp_to;

  int            n_checks;
  int            n_pass;
  int            cyc;
  int            n_ready;
  int            n_start;
  int            start_cyc;
  int            gnt_cyc;
  logic          busy_q;
  logic [1:0]    prev_gnt;

  int            spi_delay;
  bit            spi_mute;
  int            rem;
  logic [DW-1:0] resp;

  always @(posedge i_clk) begin
    cyc    <= cyc + 1;
    busy_q <= bus.i_spi_busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic void update_drive();
    bus.i_req      = {q1.size() != 0, q0.size() != 0};
    bus.i_tx_data0 = (q0.size() != 0) ? q0[0].data : '0;
    bus.i_tx_last0 = (q0.size() != 0) ? q0[0].last : 1'b0;
    bus.i_tx_data1 = (q1.size() != 0) ? q1[0].data : '0;
    bus.i_tx_last1 = (q1.size() != 0) ? q1[0].last : 1'b0;
  endfunction

  function automatic void push_word(input bit r, input logic [DW-1:0] d,
                                    input logic last, input bit rx);
    word_t w;
    w.data = d;
    w.last = last;
    if (r) q1.push_back(w);
    else   q0.push_back(w);
    exp_start.push_back(d);
    if (rx) exp_rx.push_back(~d);
    update_drive();
  endfunction

  // Requesters: advance to the next word after the capture edge of o_tx_ready.
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_rst && bus.o_tx_ready) begin
        @(posedge i_clk);
        #1;
        if (bus.o_gnt == 2'b01 && q0.size() != 0) q0.delete(0);
        else if (bus.o_gnt == 2'b10 && q1.size() != 0) q1.delete(0);
        update_drive();
      end
    end
  end

  // SPI controller: done (with ~word) spi_delay cycles after the start pulse.
  initial begin
    bus.i_spi_done = 1'b0;
    bus.i_spi_data = '0;
    rem = 0;
    forever begin
      @(negedge i_clk);
      bus.i_spi_done = 1'b0;
      if (i_rst) begin
        rem = 0;
      end else begin
        if (rem > 0) begin
          rem--;
          if (rem == 0) begin
            bus.i_spi_done = 1'b1;
            bus.i_spi_data = resp;
          end
        end
        if (bus.o_spi_start && !spi_mute) begin
          rem  = spi_delay;
          resp = ~bus.o_spi_data;
        end
      end
    end
  end

  // Output monitor / scoreboard consumer.
  initial begin
    prev_gnt = 2'b00;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        prev_gnt = 2'b00;
      end else begin
        if (bus.o_gnt != 2'b00 && prev_gnt == 2'b00) begin
          gnt_cyc = cyc;
          if (exp_gnt.size() == 0) check("gnt_extra", exp_gnt.size(), 1);
          else check("gnt_order", bus.o_gnt, exp_gnt.pop_front());
        end
        if (bus.o_gnt != 2'b00 && prev_gnt != 2'b00)
          check("gnt_held", bus.o_gnt, prev_gnt);
        if (bus.o_tx_ready) begin
          n_ready++;
          check("gnt_onehot", $onehot(bus.o_gnt), 1);
        end
        if (bus.o_spi_start) begin
          n_start++;
          start_cyc = cyc;
          check("busy_at_start", busy_q, 0);
          if (exp_start.size() == 0) check("start_extra", exp_start.size(), 1);
          else check("spi_data", bus.o_spi_data, exp_start.pop_front());
        end
        if (bus.o_rx_valid) begin
          if (exp_rx.size() == 0) check("rx_extra", exp_rx.size(), 1);
          else check("rx_data", bus.o_rx_data, exp_rx.pop_front());
        end
        if (bus.o_timeout) begin
          if (exp_to == 0) begin
            check("timeout_extra", exp_to, 1);
          end else begin
            exp_to--;
            check("timeout_delay", cyc - start_cyc, TO);
          end
        end
        prev_gnt = bus.o_gnt;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_start.size() != 0 ||
            exp_rx.size() != 0 || exp_gnt.size() != 0 || exp_to != 0) && k < budget) begin
      @(negedge i_clk);
      #1;
      k++;
    end
    check("idle_budget", k < budget, 1);
    @(negedge i_clk);
    check("gnt_released", bus.o_gnt, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},       bus.o_gnt, 0);
    check({tag, "_tx_ready"},  bus.o_tx_ready, 0);
    check({tag, "_rx_valid"},  bus.o_rx_valid, 0);
    check({tag, "_timeout"},   bus.o_timeout, 0);
    check({tag, "_spi_start"}, bus.o_spi_start, 0);
    check({tag, "_spi_data"},  bus.o_spi_data, 0);
    check({tag, "_rx_data"},   bus.o_rx_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    int base_r;
    int base_s;
    int fall_cyc;
    int rel_cyc;
    int k;

    exp_to         = 0;
    spi_delay      = 4;
    spi_mute       = 1'b0;
    bus.i_spi_busy = 1'b0;
    update_drive();

    repeat (3) @(negedge i_clk);
    check_all_zero("reset");
    i_rst = 1'b0;

    // Single word from requester 0.
    spi_delay = 16;
    exp_gnt.push_back(2'b01);
    base_r = n_ready;
    base_s = n_start;
    push_word(1'b0, 8'hA5, 1'b1, 1'b1);
    wait_idle(200);
    check("single_ready_cnt", n_ready - base_r, 1);
    check("single_start_cnt", n_start - base_s, 1);

    // Three-word burst from requester 1.
    spi_delay = 4;
    exp_gnt.push_back(2'b10);
    base_s = n_start;
    push_word(1'b1, 8'h55, 1'b0, 1'b1);
    push_word(1'b1, 8'h33, 1'b0, 1'b1);
    push_word(1'b1, 8'h0F, 1'b1, 1'b1);
    wait_idle(300);
    check("burst_start_cnt", n_start - base_s, 3);

    // Contention: both request, one-word bursts, alternating grants.
    exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b10);
    exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b10);
    push_word(1'b0, 8'h11, 1'b1, 1'b1);
    push_word(1'b1, 8'h22, 1'b1, 1'b1);
    push_word(1'b0, 8'h44, 1'b1, 1'b1);
    push_word(1'b1, 8'h88, 1'b1, 1'b1);
    wait_idle(400);

    // Busy hold for 20 cycles in START.
    bus.i_spi_busy = 1'b1;
    exp_gnt.push_back(2'b01);
    base_r = n_ready;
    push_word(1'b0, 8'hC6, 1'b1, 1'b1);
    k = 0;
    while (n_ready == base_r && k < 20) begin
      @(negedge i_clk);
      k++;
    end
    check("busy_ready_seen", n_ready - base_r, 1);
    base_s = n_start;
    repeat (20) @(negedge i_clk);
    check("busy_no_start", n_start - base_s, 0);
    bus.i_spi_busy = 1'b0;
    fall_cyc = cyc;
    wait_idle(200);
    check("busy_start_cycle", start_cyc, fall_cyc + 1);

    // Timeout: the controller never answers.
    spi_mute = 1'b1;
    exp_to   = 1;
    exp_gnt.push_back(2'b10);
    push_word(1'b1, 8'h77, 1'b1, 1'b0);
    wait_idle(200);
    spi_mute = 1'b0;

    // Done on the last allowed cycle beats the timeout.
    spi_delay = TO - 1;
    exp_gnt.push_back(2'b01);
    push_word(1'b0, 8'h3C, 1'b1, 1'b1);
    wait_idle(200);

    // Reset during WAIT of word 2 of 3.
    spi_delay = 16;
    exp_gnt.push_back(2'b01);
    base_s = n_start;
    push_word(1'b0, 8'hB1, 1'b0, 1'b1);
    push_word(1'b0, 8'hB2, 1'b0, 1'b1);
    push_word(1'b0, 8'hB3, 1'b1, 1'b1);
    k = 0;
    while (n_start - base_s < 2 && k < 200) begin
      @(negedge i_clk);
      k++;
    end
    check("rst_word2_started", n_start - base_s, 2);
    repeat (4) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check_all_zero("midrst");
    q0.delete();
    q1.delete();
    exp_start.delete();
    exp_rx.delete();
    exp_gnt.delete();
    exp_to = 0;
    update_drive();
    repeat (2) @(negedge i_clk);
    exp_gnt.push_back(2'b10);
    push_word(1'b1, 8'h9D, 1'b1, 1'b1);
    i_rst   = 1'b0;
    rel_cyc = cyc;
    wait_idle(200);
    check("rst_first_grant_cycle", gnt_cyc - rel_cyc, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
